ysyx_22051013_lsu_axi: RTL
==========================

// Module: ysyx_22051013_lsu_axi
// PURPOSE
// - Data-side AXI4 master directly downstream of the load/store unit (LSU).
// - Converts the LSU's single-cycle request (re/we, addr, wdata, byte strobe) into one single-beat 64-bit AXI read or write.
// - Returns the raw 64-bit read word for LSU byte/half/word extraction.
// - Stalls the LSU via data_not_ready until the transaction completes.
// PARAMETERS
// - AXI_ADDR_W  32  AXI address width; low bits of the 64-bit request address.
// - AXI_DATA_W  64  data bus width; fixed at 64, other values unsupported.
// - AXI_ID_W    4   ID width.
// - AXI_ID      1   constant arid/awid driven on every transaction.
// PORTS
// - clk             in   1   clock
// - rst             in   1   asynchronous active-high reset
// - re              in   1   LSU load request
// - we              in   1   LSU store request
// - data_pc         in   64  request address (loads arrive 8B-aligned)
// - data_o          in   64  store data, already lane-positioned
// - wlen            in   8   store byte strobe
// - mem_fire        in   1   LSU stage advances this cycle (result consumed)
// - data_i          out  64  registered read word
// - data_not_ready  out  1   stall to LSU
// - axi_err         out  1   sticky: non-OKAY rresp/bresp seen
// - AR channel: arvalid o1, arready i1, araddr o AXI_ADDR_W, arid o AXI_ID_W, arlen o8, arsize o3, arburst o2
// - R channel:  rvalid i1, rready o1, rdata i64, rresp i2, rlast i1, rid i AXI_ID_W
// - AW channel: awvalid o1, awready i1, awaddr, awid, awlen, awsize, awburst (widths as AR)
// - W channel:  wvalid o1, wready i1, wdata o64, wstrb o8, wlast o1
// - B channel:  bvalid i1, bready o1, bresp i2, bid i AXI_ID_W
// BEHAVIOUR
// - Reset values: every valid/ready output = 0; data_i = 0; axi_err = 0; FSM = IDLE.
// - Reset is asynchronous. Reset mid-transaction aborts to IDLE immediately; the slave is reset by the same rst.
// - Constant outputs: arlen = awlen = 0; arsize = awsize = 3'b011; burst = INCR (2'b01); wlast = 1.
// - Addressing: araddr = awaddr = {data_pc[AXI_ADDR_W-1:3], 3'b000}.
// - Request latch: in IDLE, addr/wdata/wstrb are latched into registers. These registers drive AXI.
//   LSU inputs are ignored until the FSM returns to IDLE.
// - Simultaneous re & we: the read wins; the write is dropped.
// - FSM states: IDLE, AR, R, WR, B, DONE.
//   - IDLE: re -> AR; else we -> WR; else stay.
//   - AR: arvalid = 1, held until arready; then -> R. araddr is stable while arvalid.
//   - R: rready = 1. On rvalid: data_i <= rdata; axi_err |= (rresp != 0); -> DONE.
//   - WR: awvalid and wvalid both asserted. Each drops independently after its own handshake (aw_done/w_done flags).
//     Once both handshakes are done -> B. AW and W may complete in either order or the same cycle.
//   - B: bready = 1. On bvalid: axi_err |= (bresp != 0); -> DONE.
//   - DONE: wait for mem_fire, then -> IDLE.
// - data_not_ready = (re | we) & (state != DONE). It is combinational, so the first request cycle in IDLE already stalls.
// - Minimum load latency: request in cycle 0 -> data_not_ready low in cycle 3 (arready and rvalid both immediate). Stores are the same.
// - data_i holds its value across stores and idle cycles; only a completed read updates it.
// - Error responses still complete normally. The read data is passed through unmodified.
// - rid, bid and rlast are ignored (single outstanding transaction). No new request is accepted until DONE->IDLE.
// STRUCTURE
// - define.v gains: AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY, and the FSM state encodings (one-hot, 6 bits).
// - Single flat module; no sub-module.
// TESTING
// - Load, slave always ready, rdata=64'h1122334455667788: data_not_ready high 3 cycles; data_i = that value in DONE;
//   arsize=3, araddr = data_pc & ~7.
// - Store addr 0x80000004, wstrb=8'hF0; awready delayed 2 cycles, wready immediate: wvalid drops after 1 cycle,
//   awvalid after 3 cycles; a single B completes the store.
// - re=we=1 together: only AR issued; no AW/W activity; the write is lost.
// - rresp=2'b10 on a load: the load completes; axi_err=1 and stays 1 through later OKAY transactions until rst.
// - Assert rst in state R while rvalid is pending: outputs go to reset values in the same cycle;
//   after release, a fresh load completes correctly.
// - mem_fire held low 4 cycles in DONE: FSM stays in DONE, data_not_ready=0, no new AR even with re held high.

Source files
------------

// File: rtl/ysyx_22051013_lsu_axi_pkg.sv
// Shared constants, FSM encoding and response helper for the LSU data-side AXI master.
package ysyx_22051013_lsu_axi_pkg;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_AR   = 6'b000010,
        ST_R    = 6'b000100,
        ST_WR   = 6'b001000,
        ST_B    = 6'b010000,
        ST_DONE = 6'b100000
    } lsu_state_e;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_22051013_lsu_axi_if.sv
// AXI4 bus bundle between the LSU data master and its memory slave.
interface ysyx_22051013_lsu_axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface

// File: rtl/ysyx_22051013_lsu_axi.sv
// LSU data-side AXI4 master: one single-beat 64-bit read or write per LSU request,
// stalling the LSU until the response arrives and the stage retires.
module ysyx_22051013_lsu_axi
    import ysyx_22051013_lsu_axi_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ID     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    re,
    input  logic                    we,
    input  logic [63:0]             data_pc,
    input  logic [AXI_DATA_W-1:0]   data_o,
    input  logic [AXI_DATA_W/8-1:0] wlen,
    input  logic                    mem_fire,
    output logic [AXI_DATA_W-1:0]   data_i,
    output logic                    data_not_ready,
    output logic                    axi_err,
    ysyx_22051013_lsu_axi_if.master axi
);

    localparam logic [AXI_ID_W-1:0] ID_VAL = AXI_ID_W'(AXI_ID);

    lsu_state_e state, state_nxt;

    logic [AXI_ADDR_W-1:0]   addr_q;
    logic [AXI_DATA_W-1:0]   wdata_q;
    logic [AXI_DATA_W/8-1:0] wstrb_q;
    logic                    aw_done, w_done;
    logic                    aw_hs, w_hs;

    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid  & axi.wready;

    // Single outstanding transaction, so IDs and rlast carry no information.
    logic unused_in;
    assign unused_in = ^{axi.rid, axi.bid, axi.rlast, data_pc[63:AXI_ADDR_W], data_pc[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (re)      state_nxt = ST_AR;
                else if (we) state_nxt = ST_WR;
            end
            ST_AR:   if (axi.arready) state_nxt = ST_R;
            ST_R:    if (axi.rvalid)  state_nxt = ST_DONE;
            ST_WR:   if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = ST_B;
            ST_B:    if (axi.bvalid)  state_nxt = ST_DONE;
            ST_DONE: if (mem_fire)    state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        case (state)
            ST_AR: axi.arvalid = 1'b1;
            ST_R:  axi.rready  = 1'b1;
            ST_WR: begin
                axi.awvalid = ~aw_done;
                axi.wvalid  = ~w_done;
            end
            ST_B:  axi.bready  = 1'b1;
            default: ;
        endcase
    end

    // Request fields track the LSU only while idle, so the bus sees stable values
    // for the whole transaction regardless of what the LSU does meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            data_i  <= '0;
            axi_err <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                addr_q  <= {data_pc[AXI_ADDR_W-1:3], 3'b000};
                wdata_q <= data_o;
                wstrb_q <= wlen;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == ST_WR) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (state == ST_R && axi.rvalid) begin
                data_i <= axi.rdata;
                if (resp_err(axi.rresp)) axi_err <= 1'b1;
            end
            if (state == ST_B && axi.bvalid && resp_err(axi.bresp)) axi_err <= 1'b1;
        end
    end

    assign data_not_ready = (re | we) & (state != ST_DONE);

    assign axi.araddr  = addr_q;
    assign axi.arid    = ID_VAL;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = AXI_SIZE_8B;
    assign axi.arburst = AXI_BURST_INCR;

    assign axi.awaddr  = addr_q;
    assign axi.awid    = ID_VAL;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = AXI_SIZE_8B;
    assign axi.awburst = AXI_BURST_INCR;

    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;

endmodule
